// File: rtl/data_ram_be_if.sv
// Request/response bus of the byte-enabled data RAM.
// master drives requests, slave answers one cycle later.
interface data_ram_be_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_misalign;
    logic              busy;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_misalign, busy
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_misalign, busy
    );
endinterface

// File: rtl/data_ram_be.sv
// Word-organised data RAM with RISC-V byte/half/word access,
// little-endian lanes, misalign rejection and a post-reset clear sweep.
module data_ram_be #(
    parameter int ADDR_W     = 10,
    parameter bit CLR_ON_RST = 1'b1
) (
    input logic           clk,
    input logic           rst,
    data_ram_be_if.slave  bus
);
    localparam int WA_W  = ADDR_W - 2;
    localparam int DEPTH = 2 ** WA_W;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    localparam state_t RST_STATE = CLR_ON_RST ? CLEAR : IDLE;

    state_t            state;
    state_t            state_nx;
    logic [WA_W-1:0]   cnt;
    logic [31:0]       mem [DEPTH];

    logic              is_b;
    logic              is_h;
    logic              is_w;
    logic              uns;
    logic              legal;
    logic              bad;
    logic              acc;
    logic              wr;
    logic [1:0]        lane;
    logic [WA_W-1:0]   widx;
    logic [3:0]        be;
    logic [31:0]       wsh;
    logic [31:0]       rword;
    logic [7:0]        bsel;
    logic [15:0]       hsel;
    logic [31:0]       ext;

    logic              rv_q;
    logic [31:0]       rd_q;
    logic              mis_q;

    // State register and sweep counter; reset restarts the sweep at word 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_STATE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == CLEAR)
                cnt <= cnt + 1'b1;
        end
    end

    // Next state: leave CLEAR after the last word has been zeroed.
    always_comb begin
        state_nx = state;
        if (state == CLEAR && cnt == {WA_W{1'b1}})
            state_nx = IDLE;
    end

    // FSM outputs.
    always_comb begin
        bus.busy      = (state == CLEAR);
        bus.req_ready = (state == IDLE);
    end

    // Decode size/sign, legality, alignment, lane enables and load extension.
    always_comb begin
        lane  = bus.req_addr[1:0];
        widx  = bus.req_addr[ADDR_W-1:2];
        is_b  = (bus.req_funct3[1:0] == 2'b00);
        is_h  = (bus.req_funct3[1:0] == 2'b01);
        is_w  = (bus.req_funct3[1:0] == 2'b10);
        uns   = bus.req_funct3[2];
        legal = (is_b || is_h || is_w) && !(uns && (is_w || bus.req_we));
        bad   = !legal || (is_h && lane[0]) || (is_w && lane != 2'b00);
        acc   = bus.req_valid && (state == IDLE);
        wr    = acc && bus.req_we && !bad;
        rword = mem[widx];
        bsel  = rword[8*lane +: 8];
        hsel  = lane[1] ? rword[31:16] : rword[15:0];
        be    = 4'b1111;
        wsh   = bus.req_wdata;
        ext   = rword;
        unique case (1'b1)
            is_b: begin
                be  = 4'b0001 << lane;
                wsh = {4{bus.req_wdata[7:0]}};
                ext = uns ? {24'b0, bsel} : {{24{bsel[7]}}, bsel};
            end
            is_h: begin
                be  = lane[1] ? 4'b1100 : 4'b0011;
                wsh = {2{bus.req_wdata[15:0]}};
                ext = uns ? {16'b0, hsel} : {{16{hsel[15]}}, hsel};
            end
            default: ;
        endcase
    end

    // Storage: clear sweep or lane-masked store; nothing lands while rst is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[cnt] <= '0;
            end else if (wr) begin
                for (int k = 0; k < 4; k++)
                    if (be[k])
                        mem[widx][8*k +: 8] <= wsh[8*k +: 8];
            end
        end
    end

    // One-cycle response; data only for accepted legal loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv_q  <= 1'b0;
            rd_q  <= '0;
            mis_q <= 1'b0;
        end else begin
            rv_q  <= acc;
            mis_q <= acc && bad;
            rd_q  <= (acc && !bad && !bus.req_we) ? ext : 32'h0;
        end
    end

    // Drive response outputs.
    always_comb begin
        bus.rsp_valid    = rv_q;
        bus.rsp_rdata    = rd_q;
        bus.rsp_misalign = mis_q;
    end
endmodule
